// File: rtl/float_to_int.sv
// rtl/float_to_int.sv - iterative IEEE-754 single to signed 32-bit integer converter (truncating)
// Optional saturation on overflow: define FLOAT_TO_INT_SATURATE_EN.
module float_to_int #(
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      a,
  output logic [OUT_W-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, SHIFT, SIGN, DONE} state_t;

  state_t             state_q, state_d;
  logic               sign_q, sign_d;
  logic               left_q, left_d;
  logic               ovf_q, ovf_d;
  logic               nan_q, nan_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [31:0]        m_q, m_d;
  logic [31:0]        res_q, res_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               overflow_q, overflow_d;

  logic [7:0]         a_exp;
  logic [22:0]        a_frac;

  assign a_exp  = a[30:23];
  assign a_frac = a[22:0];

  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    left_d     = left_q;
    ovf_d      = ovf_q;
    nan_d      = nan_q;
    cnt_d      = cnt_q;
    m_d        = m_q;
    res_d      = res_q;
    out_d      = out_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    busy_d     = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d  = 1'b1;
          sign_d  = a[31];
          left_d  = 1'b0;
          ovf_d   = 1'b0;
          nan_d   = 1'b0;
          cnt_d   = 5'd0;
          m_d     = {8'h00, 1'b1, a_frac};
          state_d = SHIFT;
          if (a_exp == 8'hFF) begin
            ovf_d = 1'b1;
            nan_d = |a_frac;
            m_d   = 32'h0;
          end else if (a_exp < 8'd127) begin
            // zero, denormal and |a| < 1 all truncate to zero
            m_d = 32'h0;
          end else if (a_exp == 8'd158 && a_frac == 23'h0 && a[31]) begin
            m_d = 32'h8000_0000;
          end else if (a_exp >= 8'd158) begin
            ovf_d = 1'b1;
            m_d   = 32'h0;
          end else if (a_exp >= 8'd150) begin
            left_d = 1'b1;
            cnt_d  = 5'(a_exp - 8'd150);
          end else begin
            cnt_d  = 5'(8'd150 - a_exp);
          end
        end
      end
      SHIFT: begin
        if (cnt_q == 5'd0) begin
          state_d = SIGN;
        end else begin
          m_d   = left_q ? (m_q << 1) : (m_q >> 1);
          cnt_d = cnt_q - 5'd1;
        end
      end
      SIGN: begin
        res_d = sign_q ? (32'h0 - m_q) : m_q;
        if (ovf_q) begin
`ifdef FLOAT_TO_INT_SATURATE_EN
          if (nan_q)       res_d = 32'h0000_0000;
          else if (sign_q) res_d = 32'h8000_0000;
          else             res_d = 32'h7FFF_FFFF;
`else
          res_d = 32'h8000_0000;
`endif
        end
        state_d = DONE;
      end
      DONE: begin
        out_d      = res_q[OUT_W-1:0];
        overflow_d = ovf_q;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sign_q     <= 1'b0;
      left_q     <= 1'b0;
      ovf_q      <= 1'b0;
      nan_q      <= 1'b0;
      cnt_q      <= 5'd0;
      m_q        <= 32'h0;
      res_q      <= 32'h0;
      out_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      left_q     <= left_d;
      ovf_q      <= ovf_d;
      nan_q      <= nan_d;
      cnt_q      <= cnt_d;
      m_q        <= m_d;
      res_q      <= res_d;
      out_q      <= out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  assign out      = out_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_float_to_int.sv
// tb/tb_float_to_int.sv - self-checking bench for float_to_int against a real-arithmetic reference
module tb_float_to_int;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = 32'h0;
  logic [31:0] out;
  logic        busy;
  logic        done;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  float_to_int #(.OUT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a),
    .out(out), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Reference: value of the float as a real, truncated toward zero, range-checked.
  task automatic model(input logic [31:0] av, output logic [31:0] r, output logic ov, output int lat);
    int  ex;
    real v;
    real p;
    ex = int'(av[30:23]);
    ov = 1'b0;
    r  = 32'h0;
    if (ex == 255) begin
      ov = 1'b1;
`ifdef FLOAT_TO_INT_SATURATE_EN
      r = (av[22:0] != 0) ? 32'h0 : (av[31] ? 32'h8000_0000 : 32'h7FFF_FFFF);
`else
      r = 32'h8000_0000;
`endif
    end else begin
      p = 1.0;
      if (ex >= 127) repeat (ex - 127) p = p * 2.0;
      else           repeat (127 - ex) p = p * 0.5;
      v = (ex == 0) ? 0.0 : (1.0 + real'(av[22:0]) / 8388608.0) * p;
      if (av[31]) v = -v;
      if (v >= 2147483648.0 || v < -2147483648.0) begin
        ov = 1'b1;
`ifdef FLOAT_TO_INT_SATURATE_EN
        r = av[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
        r = 32'h8000_0000;
`endif
      end else begin
        r = 32'($rtoi(v));
      end
    end
    ex = ex - 127;
    if (av[30:23] == 8'h00 || av[30:23] == 8'hFF || ex < 0 || ex >= 31) lat = 3;
    else if (ex >= 23) lat = 3 + ex - 23;
    else lat = 3 + 23 - ex;
  endtask

  task automatic convert(input logic [31:0] av);
    logic [31:0] r;
    logic        ov;
    int          lat;
    int          cyc;
    logic        seen;
    logic        busy_ok;
    model(av, r, ov, lat);
    @(negedge clk);
    a = av;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 32'hDEAD_BEEF;
    cyc = 0;
    seen = 1'b0;
    busy_ok = 1'b1;
    while (!seen && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (!busy) busy_ok = 1'b0;
      if (done) seen = 1'b1;
    end
    chk($sformatf("done_seen %h", av), 32'(seen), 32'd1);
    chk($sformatf("latency %h", av), 32'(cyc), 32'(lat));
    chk($sformatf("out %h", av), out, r);
    chk($sformatf("overflow %h", av), 32'(overflow), 32'(ov));
    chk($sformatf("busy_during %h", av), 32'(busy_ok), 32'd1);
    @(posedge clk);
    #1;
    chk($sformatf("done_fall %h", av), 32'(done), 32'd0);
    chk($sformatf("busy_fall %h", av), 32'(busy), 32'd0);
    chk($sformatf("out_held %h", av), out, r);
  endtask

  logic [31:0] directed [10] = '{
    32'h3F80_0000, 32'hC020_0000, 32'h3F00_0000, 32'h4B00_0001, 32'h4EFF_FFFF,
    32'hCF00_0000, 32'h4F00_0000, 32'h7FC0_0000, 32'hFF80_0000, 32'h0000_0001
  };

  initial begin
    logic [31:0] rv;
    logic        no_done;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", out, 32'h0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (directed[i]) convert(directed[i]);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: rv = $urandom;
        1: rv = {1'($urandom), 8'($urandom_range(120, 160)), 23'($urandom)};
        2: rv = {1'($urandom), 8'($urandom_range(150, 159)), 23'($urandom)};
        default: rv = {1'($urandom), ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00, 23'($urandom_range(0, 3))};
      endcase
      convert(rv);
    end

    // Abort: ignored start at cycle 5, reset at cycle 10.
    convert(32'h4040_0000);
    @(negedge clk);
    a = 32'h3F80_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    no_done = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = (c == 5);
      if (c == 5) a = 32'h4000_0000;
      rst_n = (c == 10) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      if (done) no_done = 1'b0;
    end
    chk("abort_no_done", 32'(no_done), 32'd1);
    chk("abort_out", out, 32'h0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    convert(32'h4000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/float_to_int.md
# float_to_int

Iterative single-precision-to-signed-integer converter for the floating-point datapath, the decode-direction counterpart of the float add/subtract unit that packs results into IEEE-754. It accepts one 32-bit float on a start strobe, unpacks sign/exponent/mantissa, aligns the mantissa one bit position per clock, applies the sign, and presents a 32-bit two's-complement result with a one-cycle done pulse. Rounding is truncation toward zero, matching the datapath's cast semantics.

## Interface
- `OUT_W`, default 32: result width. Only 32 is supported; the parameter exists for lint and bench reuse.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous reset, active-low, sampled on the rising edge of `clk`.
- `start` input 1: request strobe; accepted only while `busy`=0.
- `a` input 32: IEEE-754 single operand; sampled in the accept cycle only.
- `out` output 32: signed integer result; updated in the `done` cycle, held until the next `done`.
- `busy` output 1: high from the cycle after accept through the `done` cycle.
- `done` output 1: one-cycle pulse when `out` and `overflow` are valid.
- `overflow` output 1: result not representable (magnitude too large, Inf, NaN); valid with `done`, held with `out`.

## Operation
- States: IDLE, SHIFT, SIGN, DONE.
- IDLE: on `start`=1, latch sign s=a[31] and m={1,a[22:0]} in a 32-bit shift register, and compute e=a[30:23]-127 (signed). Go to SHIFT.
- Classification at accept, in priority order:
  - a[30:23]=255 (Inf/NaN): overflow, k=0.
  - a[30:23]=0 (zero/denormal): magnitude 0, k=0; denormals are flushed.
  - e<0: magnitude 0, k=0.
  - e=31, a[22:0]=0, s=1: exactly -2^31. Result 0x80000000, no overflow.
  - e>=31 otherwise: overflow, k=0.
  - 23<=e<=30: left shift, k=e-23 (0..7).
  - 0<=e<23: right shift, k=23-e (1..23); bits shifted out are discarded.
- SHIFT: shift m by one bit per cycle in the latched direction and decrement the step counter. Leave for SIGN the cycle the counter reads 0; the k=0 cases spend exactly one cycle here.
- SIGN: result = s ? -m : m, modulo 2^32. Overflow cases substitute the overflow value (see Configuration).
- DONE: drive `out`, `overflow`, `done`=1; return to IDLE the next cycle.
- `start` while `busy`=1 is ignored: not queued, and `a` is not resampled.
- `start` in the DONE cycle is ignored; `start` is accepted from IDLE only.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE, `out`=0, `busy`=0, `done`=0, `overflow`=0, counter=0.
- Reset mid-operation aborts the conversion. No `done` is produced and `out` is cleared to 0.
- Start accepted at edge T: `busy`=1 from T+1; `done`=1 in the cycle after edge T+3+k. Latency is 3+k cycles; max 26 (right shift by 23), min 3.
- `busy` deasserts together with `done` falling, at T+4+k; a new `start` can be accepted at that edge.
- Throughput is one conversion per 4+k cycles.

## Configuration
- `FLOAT_TO_INT_SATURATE_EN` undefined (default): every overflow case returns 0x80000000 (integer-indefinite) with `overflow`=1.
- `FLOAT_TO_INT_SATURATE_EN` defined: overflow saturates.
  - Positive overflow or +Inf: 0x7FFFFFFF.
  - Negative overflow or -Inf: 0x80000000.
  - NaN: 0x00000000.
  - `overflow`=1 in all of these cases. Non-overflow results are identical in both builds.

## Test plan
- `a`=0x3F800000 (1.0) -> `out`=0x00000001, `overflow`=0; `done` 26 cycles after accept (k=23).
- `a`=0xC0200000 (-2.5) -> `out`=0xFFFFFFFE (-2, truncation); `a`=0x3F000000 (0.5) -> `out`=0, `done` at latency 3.
- `a`=0x4B000001 (8388609.0) -> `out`=0x00800001 at latency 3; `a`=0x4EFFFFFF -> `out`=0x7FFFFF80 at latency 10.
- `a`=0xCF000000 (-2^31) -> `out`=0x80000000, `overflow`=0; `a`=0x4F000000 (2^31) -> `overflow`=1, `out`=0x80000000 by default, 0x7FFFFFFF with `FLOAT_TO_INT_SATURATE_EN`.
- `a`=0x7FC00000 (NaN) -> `overflow`=1, `out`=0x80000000 by default, 0x00000000 with the macro; `a`=0xFF800000 (-Inf) -> 0x80000000 in both builds.
- Accept 1.0, pulse `start` with 2.0 at cycle 5 (ignored), assert `rst_n`=0 at cycle 10 -> no `done`, `out`=0, `busy`=0 next cycle; a fresh `start` after reset converts normally.
